// File: rtl/core_sequencer.sv
// Multi-cycle fetch/execute/memory-wait sequencer for the 9-bit core.
// Optional single-step support is enabled with `define SEQ_SINGLE_STEP_EN.
module core_sequencer #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             halt_instr,
  input  logic             mem_op,
  input  logic             mem_ready,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic             step_mode,
  input  logic             step,
`endif
  output logic             pc_clr,
  output logic             pc_en,
  output logic             ir_load,
  output logic             wr_gate,
  output logic             mem_req,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retire_cnt
);

  localparam int unsigned TmoW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StExec,
    StMemWait,
    StHalt
`ifdef SEQ_SINGLE_STEP_EN
    , StStepHold
`endif
  } state_e;

  state_e            state_q, state_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic [CNT_W-1:0]  cycle_d, retire_d;
  logic              err_d;
  logic              retire;
  logic              busy_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    state_d  = state_q;
    tmo_d    = tmo_q;
    err_d    = err;
    cycle_d  = cycle_cnt;
    retire_d = retire_cnt;
    pc_clr   = 1'b0;
    retire   = 1'b0;

    // Hold-for-step is busy but deliberately not counted.
    if (state_q inside {StFetch, StExec, StMemWait}) cycle_d = sat_inc(cycle_cnt);

    unique case (state_q)
      StIdle, StHalt: begin
        if (start) begin
          pc_clr   = 1'b1;
          err_d    = 1'b0;
          cycle_d  = '0;
          retire_d = '0;
          state_d  = StFetch;
        end
      end
      StFetch: state_d = StExec;
      StExec: begin
        if (halt_instr) begin
          state_d = StHalt;
        end else if (mem_op) begin
          tmo_d   = '0;
          state_d = StMemWait;
        end else begin
          retire = 1'b1;
        end
      end
      StMemWait: begin
        if (mem_ready) begin
          retire = 1'b1;
        end else if (tmo_q == TmoLast) begin
          err_d   = 1'b1;
          state_d = StHalt;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
`ifdef SEQ_SINGLE_STEP_EN
      StStepHold: begin
        if (step) state_d = StFetch;
      end
`endif
      default: state_d = StIdle;
    endcase

    if (retire) begin
      retire_d = sat_inc(retire_cnt);
`ifdef SEQ_SINGLE_STEP_EN
      state_d  = step_mode ? StStepHold : StFetch;
`else
      state_d  = StFetch;
`endif
    end

    wr_gate = retire;
    pc_en   = retire;

`ifdef SEQ_SINGLE_STEP_EN
    busy_d = state_d inside {StFetch, StExec, StMemWait, StStepHold};
`else
    busy_d = state_d inside {StFetch, StExec, StMemWait};
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      tmo_q      <= '0;
      err        <= 1'b0;
      cycle_cnt  <= '0;
      retire_cnt <= '0;
      ir_load    <= 1'b0;
      mem_req    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmo_q      <= tmo_d;
      err        <= err_d;
      cycle_cnt  <= cycle_d;
      retire_cnt <= retire_d;
      ir_load    <= (state_d == StFetch);
      mem_req    <= (state_d == StMemWait);
      busy       <= busy_d;
      done       <= (state_d == StHalt);
    end
  end

endmodule
